// File: rtl/fifo_sched_pkg.sv
// ----------------------------------------------------------------------------
// fifo_sched_pkg
// Shared definitions for the round-robin FIFO scheduler and the FIFO it feeds:
//   - op_e        : scheduler operation chosen each cycle (idle / write / read)
//   - DW_DEF      : default data width, shared with the FIFO
//   - DEPTH_DEF   : default FIFO depth, shared with the FIFO
// ----------------------------------------------------------------------------
package fifo_sched_pkg;

   localparam int DW_DEF    = 8;
   localparam int DEPTH_DEF = 4;

   typedef enum logic [1:0] {
      OP_IDLE = 2'd0,
      OP_WR   = 2'd1,
      OP_RD   = 2'd2
   } op_e;

endpackage : fifo_sched_pkg

// File: rtl/fifo_rr_scheduler_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin search: the first set bit of elig_i found
// when scanning ptr_i, ptr_i+1, ... (mod NREQ). The pointer register lives in
// the parent so that it advances only when a write is actually issued.
// Ports:
//   elig_i  in  NREQ  eligible request vector
//   ptr_i   in  PW    index to start searching from
//   gnt_o   out NREQ  one-hot winner (zero when nothing eligible)
//   idx_o   out PW    winner index (0 when nothing eligible)
//   any_o   out 1     at least one eligible request
// ----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] elig_i,
   input  logic [PW-1:0]   ptr_i,
   output logic [NREQ-1:0] gnt_o,
   output logic [PW-1:0]   idx_o,
   output logic            any_o
);

   int unsigned cand_s;

   // Scan offsets from the far end back to ptr, so the last hit kept is the
   // one closest to ptr in round-robin order.
   always_comb begin
      cand_s = 0;
      idx_o  = '0;
      any_o  = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand_s = (int'(ptr_i) + k) % NREQ;
         idx_o  = elig_i[cand_s] ? PW'(cand_s) : idx_o;
         any_o  = any_o | elig_i[cand_s];
      end
      gnt_o = any_o ? (NREQ'(1) << idx_o) : '0;
   end

endmodule : rr_arbiter

// File: rtl/fifo_rr_scheduler.sv
// ----------------------------------------------------------------------------
// fifo_rr_scheduler
// Sole driver of a small synchronous FIFO shared by NREQ producers and one
// consumer. Each cycle picks at most one of write / read, arbitrates producers
// round-robin, and tracks occupancy because the FIFO has no flags of its own.
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req          per-producer write request (level, held until gnt)
//   wdata        producer i data in bits [i*DW +: DW]
//   gnt          registered one-cycle grant pulse, one-hot or zero
//   rd_req       consumer read request (level)
//   rd_valid     FIFO read data valid (fifo_r_en delayed one cycle)
//   fifo_w_en    FIFO write enable
//   fifo_wdata   FIFO write data (holds last value when not writing)
//   fifo_r_en    FIFO read enable
//   count        occupancy 0..DEPTH
//   full, empty  flags decoded from count
// ----------------------------------------------------------------------------
module fifo_rr_scheduler
   import fifo_sched_pkg::*;
#(
   parameter int NREQ  = 4,
   parameter int DW    = DW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*DW-1:0] wdata,
   output logic [NREQ-1:0]  gnt,
   input  logic             rd_req,
   output logic             rd_valid,
   output logic             fifo_w_en,
   output logic [DW-1:0]    fifo_wdata,
   output logic             fifo_r_en,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(NREQ);

   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            w_en_q, w_en_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            r_en_q, r_en_d;
   logic            rd_valid_q;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   op_e             last_q, last_d;

   logic [NREQ-1:0] elig_s;
   logic [NREQ-1:0] win_oh_s;
   logic [PW-1:0]   win_idx_s;
   logic            win_any_s;
   logic            wr_ok_s;
   logic            rd_ok_s;
   op_e             op_s;

   // A producer granted last cycle may still hold req; mask it so it cannot win twice.
   assign elig_s  = req & ~gnt_q;
   assign wr_ok_s = win_any_s && (count_q < CW'(DEPTH));
   assign rd_ok_s = rd_req && (count_q != CW'(0));

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .elig_i (elig_s),
      .ptr_i  (ptr_q),
      .gnt_o  (win_oh_s),
      .idx_o  (win_idx_s),
      .any_o  (win_any_s)
   );

   // Operation select: contested slots alternate against the last issued op.
   always_comb begin
      op_s = OP_IDLE;
      case ({wr_ok_s, rd_ok_s})
         2'b10:   op_s = OP_WR;
         2'b01:   op_s = OP_RD;
         2'b11:   op_s = (last_q == OP_WR) ? OP_RD : OP_WR;
         default: op_s = OP_IDLE;
      endcase
   end

   // Next-state for strobes, data, occupancy, pointer and alternation history.
   always_comb begin
      gnt_d   = '0;
      w_en_d  = 1'b0;
      r_en_d  = 1'b0;
      wdata_d = wdata_q;
      count_d = count_q;
      ptr_d   = ptr_q;
      last_d  = last_q;
      case (op_s)
         OP_WR: begin
            gnt_d   = win_oh_s;
            w_en_d  = 1'b1;
            wdata_d = wdata[int'(win_idx_s)*DW +: DW];
            ptr_d   = (win_idx_s == PW'(NREQ - 1)) ? PW'(0) : (win_idx_s + PW'(1));
            count_d = count_q + CW'(1);
            last_d  = OP_WR;
         end
         OP_RD: begin
            r_en_d  = 1'b1;
            count_d = count_q - CW'(1);
            last_d  = OP_RD;
         end
         default: begin
            gnt_d = '0;
         end
      endcase
   end

   // State registers; last_q resets to RD so the first contested slot writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q      <= '0;
         w_en_q     <= 1'b0;
         wdata_q    <= '0;
         r_en_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         count_q    <= '0;
         ptr_q      <= '0;
         last_q     <= OP_RD;
      end else begin
         gnt_q      <= gnt_d;
         w_en_q     <= w_en_d;
         wdata_q    <= wdata_d;
         r_en_q     <= r_en_d;
         rd_valid_q <= r_en_q;
         count_q    <= count_d;
         ptr_q      <= ptr_d;
         last_q     <= last_d;
      end
   end

   assign gnt        = gnt_q;
   assign fifo_w_en  = w_en_q;
   assign fifo_wdata = wdata_q;
   assign fifo_r_en  = r_en_q;
   assign rd_valid   = rd_valid_q;
   assign count      = count_q;
   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == CW'(0));

endmodule : fifo_rr_scheduler
